// File: rtl/lsu_mem_requester.sv
// Load/store initiator between the MEM stage and the memory controller data port.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned loads fault without a memory access.
module lsu_mem_requester #(
   parameter int DATA_WIDTH = 64,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [DATA_WIDTH-1:0] req_addr_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   input  logic [2:0]            req_wid_i,
   output logic                  resp_valid_o,
   input  logic                  resp_ready_i,
   output logic [DATA_WIDTH-1:0] resp_rdata_o,
   output logic                  resp_err_o,
   output logic [DATA_WIDTH-1:0] mem_addr_o,
   output logic                  mem_en_o,
   output logic                  mem_enwr_o,
   output logic [2:0]            mem_wid_o,
   output logic [DATA_WIDTH-1:0] mem_data_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   input  logic                  mem_unalign_i
);

   typedef enum logic [1:0] {IDLE, ST_ISSUE, RD_WAIT, RESP} state_t;

   state_t                r_state, w_nxt_state;
   logic [DATA_WIDTH-1:0] r_addr, w_nxt_addr;
   logic [DATA_WIDTH-1:0] r_wdata, w_nxt_wdata;
   logic [2:0]            r_wid, w_nxt_wid;
   logic                  r_en, w_nxt_en;
   logic                  r_enwr, w_nxt_enwr;
   logic [1:0]            r_cnt, w_nxt_cnt;
   logic [DATA_WIDTH-1:0] r_rdata, w_nxt_rdata;
   logic                  r_err, w_nxt_err;
   logic                  w_load_trap;
   logic [31:0]           w_sh;
   logic [DATA_WIDTH-1:0] w_ext;

`ifdef LSU_MISALIGN_TRAP_EN
   always_comb begin
      w_load_trap = 1'b0;
      case (req_wid_i)
         3'd1, 3'd5: w_load_trap = req_addr_i[0];
         3'd2, 3'd6: w_load_trap = |req_addr_i[1:0];
         3'd3:       w_load_trap = |req_addr_i[2:0];
         default:    w_load_trap = 1'b0;
      endcase
   end
`else
   assign w_load_trap = 1'b0;
`endif

   // Bytes shifted past the top of the dword come in as zeros before extension.
   assign w_sh = 32'(mem_rdata_i >> {r_addr[2:0], 3'b000});

   always_comb begin
      case (r_wid)
         3'd0:    w_ext = {{(DATA_WIDTH-8){w_sh[7]}}, w_sh[7:0]};
         3'd1:    w_ext = {{(DATA_WIDTH-16){w_sh[15]}}, w_sh[15:0]};
         3'd2:    w_ext = {{(DATA_WIDTH-32){w_sh[31]}}, w_sh[31:0]};
         3'd3:    w_ext = mem_rdata_i;
         3'd4:    w_ext = {{(DATA_WIDTH-8){1'b0}}, w_sh[7:0]};
         3'd5:    w_ext = {{(DATA_WIDTH-16){1'b0}}, w_sh[15:0]};
         3'd6:    w_ext = {{(DATA_WIDTH-32){1'b0}}, w_sh[31:0]};
         default: w_ext = '0;
      endcase
   end

   always_comb begin
      // NOTE: every next-state value is defaulted first so no path infers a latch.
      w_nxt_state = r_state;
      w_nxt_addr  = r_addr;
      w_nxt_wdata = r_wdata;
      w_nxt_wid   = r_wid;
      w_nxt_en    = r_en;
      w_nxt_enwr  = r_enwr;
      w_nxt_cnt   = r_cnt;
      w_nxt_rdata = r_rdata;
      w_nxt_err   = r_err;
      case (r_state)
         IDLE: begin
            if (req_valid_i) begin
               w_nxt_addr  = req_addr_i;
               w_nxt_wdata = req_wdata_i;
               w_nxt_wid   = req_wid_i;
               if (req_wid_i == 3'd7 || (!req_we_i && w_load_trap)) begin
                  w_nxt_state = RESP;
                  w_nxt_err   = 1'b1;
                  w_nxt_rdata = '0;
               end else if (req_we_i) begin
                  w_nxt_state = ST_ISSUE;
                  w_nxt_en    = 1'b1;
                  w_nxt_enwr  = 1'b0;
               end else begin
                  w_nxt_state = RD_WAIT;
                  w_nxt_en    = 1'b1;
                  w_nxt_enwr  = 1'b1;
                  w_nxt_cnt   = 2'(RD_LATENCY - 1);
               end
            end
         end
         ST_ISSUE: begin
            w_nxt_state = RESP;
            w_nxt_err   = mem_unalign_i;
            w_nxt_rdata = '0;
            w_nxt_en    = 1'b0;
            w_nxt_enwr  = 1'b1;
         end
         RD_WAIT: begin
            if (r_cnt == 2'd0) begin
               w_nxt_state = RESP;
               w_nxt_rdata = w_ext;
               w_nxt_err   = 1'b0;
               w_nxt_en    = 1'b0;
            end else begin
               w_nxt_cnt = r_cnt - 2'd1;
            end
         end
         RESP: begin
            if (resp_ready_i) begin
               w_nxt_state = IDLE;
               w_nxt_rdata = '0;
               w_nxt_err   = 1'b0;
            end
         end
         default: w_nxt_state = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wid   <= 3'd0;
         r_en    <= 1'b0;
         r_enwr  <= 1'b1;
         r_cnt   <= 2'd0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_nxt_state;
         r_addr  <= w_nxt_addr;
         r_wdata <= w_nxt_wdata;
         r_wid   <= w_nxt_wid;
         r_en    <= w_nxt_en;
         r_enwr  <= w_nxt_enwr;
         r_cnt   <= w_nxt_cnt;
         r_rdata <= w_nxt_rdata;
         r_err   <= w_nxt_err;
      end
   end

   assign req_ready_o  = (r_state == IDLE);
   assign resp_valid_o = (r_state == RESP);
   assign resp_rdata_o = r_rdata;
   assign resp_err_o   = r_err;
   assign mem_addr_o   = r_addr;
   assign mem_en_o     = r_en;
   assign mem_enwr_o   = r_enwr;
   assign mem_wid_o    = r_wid;
   assign mem_data_o   = r_wdata;

endmodule
